// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, one-hot key encoder and entry FSM states.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } entry_state_e;

    // Only an exactly-one-hot word names a key; idle or chorded words read as NONE.
    function automatic logic [3:0] encode_key(input logic [11:0] key_word);
        logic [3:0] code;
        case (key_word)
            12'h001: code = 4'd1;
            12'h002: code = 4'd2;
            12'h004: code = 4'd3;
            12'h008: code = 4'd4;
            12'h010: code = 4'd5;
            12'h020: code = 4'd6;
            12'h040: code = 4'd7;
            12'h080: code = 4'd8;
            12'h100: code = 4'd9;
            12'h200: code = KEY_STAR;
            12'h400: code = 4'd0;
            12'h800: code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Synchronises and debounces the scanner key word; raises one event per physical press.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int SAMPLE_DIV   = 25000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_data,
    output logic        press,
    output logic [3:0]  press_code,
    output logic        key_evt,
    output logic [3:0]  key_code
);

    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);

    logic [11:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    cand_q, cand_d, acc_q, acc_d, key_code_q, key_code_d;
    logic [CW-1:0] stable_q, stable_d;
    logic          key_evt_q, key_evt_d;
    logic          tick_s;
    logic [3:0]    code_s;

    // Next-state for synchroniser, prescaler, debounce filter and press detection.
    always_comb begin
        sync1_d  = key_data;
        sync2_d  = sync1_q;
        code_s   = encode_key(sync2_q);
        tick_s   = (pre_q == DIV_LAST);
        cand_d   = cand_q;
        stable_d = stable_q;
        acc_d    = acc_q;
        if (tick_s) begin
            pre_d = '0;
            if (code_s != cand_q) begin
                cand_d   = code_s;
                stable_d = CW'(1);
            end else if (stable_q != CNT_MAX) begin
                stable_d = stable_q + 1'b1;
            end else begin
                stable_d = stable_q;
            end
            // Acceptance uses the updated count so DEBOUNCE_CNT=1 accepts on first sight.
            if (stable_d == CNT_MAX) begin
                acc_d = cand_d;
            end else begin
                acc_d = acc_q;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
        press      = (acc_q == KEY_NONE) && (acc_d != KEY_NONE);
        press_code = acc_d;
        key_evt_d  = press;
        key_code_d = press ? acc_d : key_code_q;
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 12'h000;
            sync2_q    <= 12'h000;
            pre_q      <= '0;
            cand_q     <= KEY_NONE;
            stable_q   <= '0;
            acc_q      <= KEY_NONE;
            key_evt_q  <= 1'b0;
            key_code_q <= 4'h0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pre_q      <= pre_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            acc_q      <= acc_d;
            key_evt_q  <= key_evt_d;
            key_code_q <= key_code_d;
        end
    end

    assign key_evt  = key_evt_q;
    assign key_code = key_code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: builds a BCD entry from debounced presses and hands
// committed entries downstream over valid/ready.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int SAMPLE_DIV   = 25000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int MAX_DIGITS   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [11:0]                        key_data,
    output logic                               key_evt,
    output logic [3:0]                         key_code,
    output logic [4*MAX_DIGITS-1:0]            disp_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    disp_len,
    output logic                               overflow,
    output logic                               entry_valid,
    input  logic                               entry_ready,
    output logic [4*MAX_DIGITS-1:0]            entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    entry_len
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int LW = $clog2(MAX_DIGITS + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DIGITS);

    logic          press_s;
    logic [3:0]    press_code_s;
    entry_state_e  state_q, state_d;
    logic [BW-1:0] disp_bcd_q, disp_bcd_d, entry_bcd_q, entry_bcd_d, shifted_s;
    logic [LW-1:0] disp_len_q, disp_len_d, entry_len_q, entry_len_d;
    logic          entry_valid_q, entry_valid_d, overflow_q, overflow_d;

    keypad_debounce #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .press      (press_s),
        .press_code (press_code_s),
        .key_evt    (key_evt),
        .key_code   (key_code)
    );

    // Entry FSM: acts on the press strobe so buffer updates land with key_evt.
    always_comb begin
        state_d       = state_q;
        disp_bcd_d    = disp_bcd_q;
        disp_len_d    = disp_len_q;
        entry_bcd_d   = entry_bcd_q;
        entry_len_d   = entry_len_q;
        entry_valid_d = entry_valid_q;
        overflow_d    = 1'b0;
        shifted_s     = disp_bcd_q << 4'd4;
        shifted_s[3:0] = press_code_s;
        case (state_q)
            COLLECT: begin
                if (press_s && (press_code_s <= 4'd9)) begin
                    if (disp_len_q < MAX_LEN) begin
                        disp_bcd_d = shifted_s;
                        disp_len_d = disp_len_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (press_s && (press_code_s == KEY_STAR)) begin
                    if (disp_len_q != '0) begin
                        disp_bcd_d = disp_bcd_q >> 4'd4;
                        disp_len_d = disp_len_q - 1'b1;
                    end else begin
                        disp_len_d = disp_len_q;
                    end
                end else if (press_s && (press_code_s == KEY_HASH)) begin
                    if (disp_len_q != '0) begin
                        entry_bcd_d   = disp_bcd_q;
                        entry_len_d   = disp_len_q;
                        entry_valid_d = 1'b1;
                        state_d       = COMMIT;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            COMMIT: begin
                // Keys are ignored here; only the handshake releases the entry.
                if (entry_valid_q && entry_ready) begin
                    entry_valid_d = 1'b0;
                    disp_bcd_d    = '0;
                    disp_len_d    = '0;
                    state_d       = COLLECT;
                end else begin
                    state_d = COMMIT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Entry FSM and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= COLLECT;
            disp_bcd_q    <= '0;
            disp_len_q    <= '0;
            entry_bcd_q   <= '0;
            entry_len_q   <= '0;
            entry_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_len_q    <= disp_len_d;
            entry_bcd_q   <= entry_bcd_d;
            entry_len_q   <= entry_len_d;
            entry_valid_q <= entry_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign disp_bcd    = disp_bcd_q;
    assign disp_len    = disp_len_q;
    assign overflow    = overflow_q;
    assign entry_valid = entry_valid_q;
    assign entry_bcd   = entry_bcd_q;
    assign entry_len   = entry_len_q;

endmodule
